// File: rtl/mbinit_pkg.sv
// Shared MBINIT definitions: FSM state encodings and sideband message codes
// used by the partner-side responder and its sequencer-side twin.
package mbinit_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_REQ  = 3'd1;
  localparam logic [2:0] ST_SEND_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  // Decoded sideband message codes for the MBINIT request/response substates.
  localparam logic [3:0] MSG_CAL_DONE_REQ        = 4'b0001;
  localparam logic [3:0] MSG_CAL_DONE_RESP       = 4'b0010;
  localparam logic [3:0] MSG_REPAIRCLK_INIT_REQ  = 4'b0011;
  localparam logic [3:0] MSG_REPAIRCLK_INIT_RESP = 4'b0100;
  localparam logic [3:0] MSG_REPAIRCLK_DONE_REQ  = 4'b0101;
  localparam logic [3:0] MSG_REPAIRCLK_DONE_RESP = 4'b0110;
  localparam logic [3:0] MSG_REPAIRVAL_INIT_REQ  = 4'b0111;
  localparam logic [3:0] MSG_REPAIRVAL_INIT_RESP = 4'b1000;
  localparam logic [3:0] MSG_REPAIRVAL_DONE_REQ  = 4'b1001;
  localparam logic [3:0] MSG_REPAIRVAL_DONE_RESP = 4'b1010;

endpackage

// File: rtl/sb_timeout_counter.sv
// Saturating cycle counter with a one-before-limit expire flag; a LIMIT of 0
// disables expiry entirely.
module sb_timeout_counter #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  generate
    if (LIMIT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      assign expire = (count == CNT_W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/mbinit_partner_handshake.sv
// Partner-side MBINIT responder: waits for the partner's request each round,
// answers with the matching response and reports done or request timeout.
module mbinit_partner_handshake
  import mbinit_pkg::*;
#(
  parameter int unsigned         MSG_W       = 4,
  parameter int unsigned         DATA_W      = 16,
  parameter logic [MSG_W-1:0]    REQ_CODE    = MSG_CAL_DONE_REQ,
  parameter logic [MSG_W-1:0]    RESP_CODE   = MSG_CAL_DONE_RESP,
  parameter int unsigned         NUM_ROUNDS  = 1,
  parameter int unsigned         ECHO_DATA   = 1,
  parameter int unsigned         TIMEOUT_CYC = 1024,
  localparam int unsigned        RND_W       = $clog2(NUM_ROUNDS + 1)
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [MSG_W-1:0]  i_RX_SbMessage,
  input  logic              i_rx_msg_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_Busy_SideBand,
  output logic [MSG_W-1:0]  o_TX_SbMessage,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_ValidOutDatat_ModulePartner,
  output logic [RND_W-1:0]  o_round,
  output logic              o_done,
  output logic              o_timeout_err
);

  logic [2:0]        cs, ns;
  logic              busy_q;
  logic              busy_fall;
  logic [RND_W-1:0]  rnd_d;
  logic [DATA_W-1:0] cap_q;
  logic [MSG_W-1:0]  req_exp;
  logic [MSG_W-1:0]  resp_cur;
  logic              req_hit;
  logic              tmr_expire;

  assign busy_fall = busy_q & ~i_Busy_SideBand;
  assign req_exp   = REQ_CODE + MSG_W'(o_round);
  assign resp_cur  = RESP_CODE + MSG_W'(o_round);
  assign req_hit   = i_rx_msg_valid && (i_RX_SbMessage == req_exp);

  // Timer runs only while waiting for a request; any other state restarts it.
  sb_timeout_counter #(
    .LIMIT (TIMEOUT_CYC)
  ) u_req_timer (
    .clk    (CLK),
    .rst    (rst),
    .enable (cs == ST_WAIT_REQ),
    .clear  (cs != ST_WAIT_REQ),
    .expire (tmr_expire)
  );

  always_comb begin
    ns    = cs;
    rnd_d = o_round;
    case (cs)
      ST_IDLE: begin
        rnd_d = '0;
        if (i_enable) ns = ST_WAIT_REQ;
      end
      ST_WAIT_REQ: begin
        if (req_hit)         ns = ST_SEND_WAIT;
        else if (tmr_expire) ns = ST_ERROR;
      end
      ST_SEND_WAIT: begin
        if (!i_Busy_SideBand) ns = ST_SEND;
      end
      ST_SEND: begin
        if (busy_fall) begin
          rnd_d = o_round + RND_W'(1);
          ns    = (rnd_d == RND_W'(NUM_ROUNDS)) ? ST_DONE : ST_WAIT_REQ;
        end
      end
      ST_DONE, ST_ERROR: ;
      default: ns = ST_IDLE;
    endcase
    if (!i_enable) begin
      ns    = ST_IDLE;
      rnd_d = '0;
    end
  end

  // Outputs are decoded from the next state so they track the transition
  // on the following cycle; o_round is the round register itself.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cs                            <= ST_IDLE;
      busy_q                        <= 1'b0;
      cap_q                         <= '0;
      o_round                       <= '0;
      o_TX_SbMessage                <= '0;
      o_tx_data                     <= '0;
      o_ValidOutDatat_ModulePartner <= 1'b0;
      o_done                        <= 1'b0;
      o_timeout_err                 <= 1'b0;
    end else begin
      cs      <= ns;
      busy_q  <= i_Busy_SideBand;
      o_round <= rnd_d;
      if ((cs == ST_WAIT_REQ) && req_hit) cap_q <= i_rx_data;
      o_ValidOutDatat_ModulePartner <= (ns == ST_SEND);
      o_TX_SbMessage <= (ns == ST_SEND) ? resp_cur : '0;
      o_tx_data      <= ((ns == ST_SEND) && (ECHO_DATA != 0)) ? cap_q : '0;
      o_done         <= (ns == ST_DONE);
      o_timeout_err  <= (ns == ST_ERROR);
    end
  end

endmodule

// File: doc/mbinit_partner_handshake.md
Name: mbinit_partner_handshake

Overview:
- Generalised partner-side responder for MBINIT sideband request/response substates (CAL, REPAIRCLK, REPAIRVAL, ...).
- Sits between the LTSM MBINIT sequencer and the sideband TX/RX message interface.
- Waits for the link partner's request and sends the matching response. Repeats for NUM_ROUNDS rounds, optionally echoing a data field.
- Adds a request timeout and an error exit.

Parameters:
- MSG_W, 4, width of sideband message code
- DATA_W, 16, width of message data field
- REQ_CODE, 4'b0001, request code for round 0; round k expects REQ_CODE+k
- RESP_CODE, 4'b0010, response code for round 0; round k sends RESP_CODE+k
- NUM_ROUNDS, 1, number of request/response rounds (1..8)
- ECHO_DATA, 1, 1: o_tx_data = captured i_rx_data; 0: o_tx_data = 0
- TIMEOUT_CYC, 1024, max cycles waiting for a request (0 disables)

Ports:
- CLK  in  1  clock
- rst  in  1  synchronous active-high reset
- i_enable  in  1  substate enable from MBINIT sequencer; low aborts to IDLE
- i_RX_SbMessage  in  MSG_W  decoded received message code
- i_rx_msg_valid  in  1  one-cycle strobe, i_RX_SbMessage/i_rx_data valid
- i_rx_data  in  DATA_W  received data field
- i_Busy_SideBand  in  1  sideband TX busy
- o_TX_SbMessage  out  MSG_W  response code to send
- o_tx_data  out  DATA_W  response data field
- o_ValidOutDatat_ModulePartner  out  1  TX request valid
- o_round  out  $clog2(NUM_ROUNDS+1)  completed round count
- o_done  out  1  all rounds complete, level
- o_timeout_err  out  1  request timeout, level

Behaviour:
- Single clock CLK. Synchronous active-high rst: on the rst cycle, CS=IDLE and all outputs are 0, including counters and busy_q.
- All outputs are registered and decoded from NS, so they reflect the new state on the cycle after the transition decision.
- busy_q registers i_Busy_SideBand. busy_fall = busy_q & ~i_Busy_SideBand is detected internally, with no external edge input.
- States and transitions:
  - IDLE: go to WAIT_REQ when i_enable=1. Clears the round counter, timer and error.
  - WAIT_REQ: go to SEND_WAIT when i_rx_msg_valid & i_RX_SbMessage == REQ_CODE+round. Captures i_rx_data on that cycle. Other codes are ignored. The timer increments each cycle. When the timer reaches TIMEOUT_CYC-1 with no match, go to ERROR.
  - SEND_WAIT: go to SEND when i_Busy_SideBand=0.
  - SEND: o_ValidOut=1, o_TX_SbMessage=RESP_CODE+round, o_tx_data per ECHO_DATA. Holds until busy_fall.
    - On busy_fall, round increments.
    - If round+1 == NUM_ROUNDS, go to DONE.
    - Otherwise go to WAIT_REQ and clear the timer.
  - DONE: o_done=1 and o_round=NUM_ROUNDS. Hold.
  - ERROR: o_timeout_err=1. Hold.
- i_enable=0 in any state: next state is IDLE and outputs go 0 the following cycle. This includes mid-send: valid drops even if the sideband is busy.
- A request that matches on the same cycle as the timeout threshold is accepted; the match wins.
- Request codes for future rounds are ignored, not buffered.
- A busy_fall that arrives in SEND_WAIT, before valid is asserted, is ignored.
- Arithmetic: REQ_CODE+round and RESP_CODE+round are MSG_W-bit and wrap modulo 2^MSG_W.
- Timer width is $clog2(TIMEOUT_CYC+1). The timer saturates and does not wrap.
- Latency: the request strobe reaches o_ValidOut 2 cycles later if the sideband is idle. busy_fall reaches o_done 1 cycle later.

Decomposition:
- Shared package mbinit_pkg:
  - state encoding localparams (IDLE, WAIT_REQ, SEND_WAIT, SEND, DONE, ERROR)
  - MBINIT sideband message code constants (CAL_Done_req/resp, REPAIRCLK, REPAIRVAL, ...)
- One sub-module, sb_timeout_counter: enable, clear, saturating count, expire flag. It is reused by the sequencer-side twin.

Test Plan:
- NUM_ROUNDS=1, enable, request 4'b0001 with data 16'hA5A5, busy low → valid=1, TX=4'b0010, tx_data=16'hA5A5 at +2 cycles. Busy 1 for 3 cycles then 0 → o_done=1 next cycle, o_round=1.
- Busy high when the request arrives → valid stays 0 until busy low. Busy then pulses 1→0 → exactly one response, then done.
- NUM_ROUNDS=3 → requests 0001, 0010, 0011 produce responses 0010, 0011, 0100 in order. A stray 0011 during round 0 is ignored. Done only after the third busy_fall.
- TIMEOUT_CYC=8, no request → o_timeout_err=1 after 8 cycles in WAIT_REQ. A request on cycle 7 → no error, response sent.
- i_enable dropped while in SEND → next cycle valid=0, TX=0. Re-enable → fresh round 0, timer cleared.
- rst asserted mid-round → all outputs 0 on the following edge and state IDLE. ECHO_DATA=0 → tx_data=0 regardless of request data.
